// File: rtl/dram_resp_pkg.sv
// Shared constants for the DRAM response model: FSM states, default access delay
// and byte-enable expansion.
package dram_resp_pkg;

  localparam int mem_delay_const = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/dram_array.sv
// Single-port word array: synchronous byte-enabled write, combinational read of the same index.
// Contents are never reset.
module dram_array
  import dram_resp_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] w_mask;

  assign w_mask = be_mask(i_be);

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wdata & w_mask);
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dram_resp.sv
// Fixed-latency DRAM responder: accepts one access, waits MEM_DELAY cycles, then completes
// with a one-cycle valid; stall holds the pipeline from accept until completion.
module dram_resp
  import dram_resp_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int MEM_DELAY = mem_delay_const
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        stall,
  output logic        err
);

  localparam int         AW      = $clog2(MEM_WORDS);
  localparam bit         NO_WAIT = (MEM_DELAY == 0);
  localparam logic [3:0] LAST    = NO_WAIT ? 4'd0 : 4'(MEM_DELAY - 1);

  state_e          r_state;
  logic [3:0]      r_cnt;
  logic            r_wr;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [31:0]     r_rdata;
  logic            r_valid;
  logic            r_err;

  logic            w_open;
  logic            w_req;
  logic            w_accept;
  logic            w_fin;
  logic            w_op_wr;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_wdata;
  logic [3:0]      w_be;
  logic [31:0]     w_arr_rdata;
  logic            w_unused_addr;

  assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_req    = re | we;
  assign w_accept = nrst & w_open & w_req;
  assign stall    = nrst & ((w_open & w_req) | (r_state == S_WAIT));

  // With zero delay the access completes on its accept edge, straight from the ports.
  assign w_op_wr = NO_WAIT ? we               : r_wr;
  assign w_idx   = NO_WAIT ? addr[AW+1:2]     : r_idx;
  assign w_wdata = NO_WAIT ? wdata            : r_wdata;
  assign w_be    = NO_WAIT ? be               : r_be;
  assign w_fin   = NO_WAIT ? w_accept
                           : (nrst & (r_state == S_WAIT) & (r_cnt == LAST));

  assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};

  dram_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_fin & w_op_wr),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .i_be    (w_be),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_fin;
      if (w_fin && !w_op_wr) r_rdata <= w_arr_rdata;
      if (w_accept && re && we) r_err <= 1'b1;
      case (r_state)
        S_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST) r_state <= S_DONE;
        end
        default: begin
          if (w_req) begin
            r_cnt   <= 4'd0;
            r_state <= NO_WAIT ? S_DONE : S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Request is captured at accept; re/we seen during WAIT never disturb it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr    <= we;
      r_idx   <= addr[AW+1:2];
      r_wdata <= wdata;
      r_be    <= be;
    end
  end

  assign rdata = r_rdata;
  assign valid = r_valid;
  assign err   = r_err;

endmodule

// File: tb/tb_dram_resp.sv
// Bench for dram_resp: directed table, reset-abort and back-to-back sequences, random traffic
// against a transaction-level memory model, plus a zero-delay instance.
module tb_dram_resp;

  localparam int DELAY = 4;

  logic        clk;
  logic        nrst;
  logic        re, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        valid, stall, err;

  logic        re0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic [31:0] rdata0;
  logic        valid0, stall0, err0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m [256];
  logic [31:0] exp_rdata;
  logic        err_m;
  bit          pend;
  logic [31:0] pend_rdata;
  logic [31:0] ra;
  int          op;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [10];

  dram_resp #(.MEM_WORDS(256), .MEM_DELAY(DELAY)) u_dut (
    .clk(clk), .nrst(nrst), .re(re), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata), .valid(valid), .stall(stall), .err(err)
  );

  dram_resp #(.MEM_WORDS(256), .MEM_DELAY(0)) u_dut0 (
    .clk(clk), .nrst(nrst), .re(re0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .rdata(rdata0), .valid(valid0), .stall(stall0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    re = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
  endtask

  // One access on the DELAY instance; the model updates at accept. With b2b the DONE
  // cycle is left pending so the next access is presented in it.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input bit b2b);
    logic [7:0] idx;
    re = r; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    chk("stall_accept", 32'(stall), 32'd1);
    if (pend) begin
      chk("valid_b2b", 32'(valid), 32'd1);
      chk("rdata_b2b", rdata, pend_rdata);
      chk("err_b2b", 32'(err), 32'(err_m));
    end else begin
      chk("valid_before", 32'(valid), 32'd0);
    end
    pend = 1'b0;
    idx = a[9:2];
    if (w) begin
      for (int i = 0; i < 4; i++) if (b[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
      if (r) err_m = 1'b1;
    end else begin
      exp_rdata = mem_m[idx];
    end
    @(posedge clk); #1;
    for (int c = 1; c <= DELAY; c++) begin
      re = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
      @(negedge clk);
      chk("stall_wait", 32'(stall), 32'd1);
      chk("valid_wait", 32'(valid), 32'd0);
      @(posedge clk); #1;
    end
    pend = 1'b1;
    pend_rdata = exp_rdata;
    if (!b2b) begin
      idle();
      @(negedge clk);
      chk("stall_done", 32'(stall), 32'd0);
      chk("valid_done", 32'(valid), 32'd1);
      chk("rdata_done", rdata, exp_rdata);
      chk("err_done", 32'(err), 32'(err_m));
      pend = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0102_0304, 4'hF, 32'h11BB_33DD, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'h0102_0304, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_0040, 32'h55AA_55AA, 4'hF, 32'h0102_0304, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h55AA_55AA, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 32'hFFFF_FC12, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b1};

    re0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0; be0 = 4'd0;
    exp_rdata = 32'd0; err_m = 1'b0; pend = 1'b0; pend_rdata = 32'd0;

    // Reset with a request present: stall must stay low.
    nrst = 1'b0;
    idle();
    re = 1'b1;
    @(negedge clk);
    chk("stall_in_reset", 32'(stall), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) begin
      access(tbl[k].r, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].b, 1'b0);
      chk($sformatf("tbl%0d_rdata", k), rdata, tbl[k].exp_rdata);
      chk($sformatf("tbl%0d_err", k), 32'(err), 32'(tbl[k].exp_err));
    end

    // Reset in the second WAIT cycle of a write aborts it.
    access(1'b0, 1'b1, 32'h30, 32'h1234_5678, 4'hF, 1'b0);
    re = 1'b0; we = 1'b1; addr = 32'h30; wdata = 32'hFFFF_FFFF; be = 4'hF;
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    chk("abort_stall_low", 32'(stall), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    exp_rdata = 32'd0; err_m = 1'b0;
    access(1'b1, 1'b0, 32'h30, 32'd0, 4'd0, 1'b0);
    chk("abort_old_word", rdata, 32'h1234_5678);

    // Fill words 0..15 through aliased addresses, then random traffic over them.
    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      ra[9:2] = 8'(k);
      access(1'b0, 1'b1, ra, $urandom, 4'hF, 1'b0);
    end
    for (int k = 0; k < 60; k++) begin
      ra = $urandom;
      ra[9:2] = 8'($urandom_range(0, 15));
      op = int'($urandom_range(0, 9));
      access(op < 5, op >= 4, ra, $urandom, 4'($urandom),
             (k != 59) && ($urandom_range(0, 1) == 1));
    end

    // Back-to-back reads: second presented in the DONE cycle of the first.
    access(1'b1, 1'b0, 32'h0, 32'd0, 4'd0, 1'b1);
    access(1'b1, 1'b0, 32'h4, 32'd0, 4'd0, 1'b0);
    chk("b2b_last_rdata", rdata, mem_m[1]);

    // Zero-delay instance: write, read presented in DONE, then idle.
    we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hCAFE_F00D; be0 = 4'hF;
    @(negedge clk);
    chk("d0_stall_wr", 32'(stall0), 32'd1);
    chk("d0_valid_pre", 32'(valid0), 32'd0);
    @(posedge clk); #1;
    we0 = 1'b0; re0 = 1'b1;
    @(negedge clk);
    chk("d0_valid_wr", 32'(valid0), 32'd1);
    chk("d0_stall_rd", 32'(stall0), 32'd1);
    @(posedge clk); #1;
    re0 = 1'b0;
    @(negedge clk);
    chk("d0_valid_rd", 32'(valid0), 32'd1);
    chk("d0_rdata", rdata0, 32'hCAFE_F00D);
    chk("d0_stall_idle", 32'(stall0), 32'd0);
    chk("d0_err", 32'(err0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("d0_valid_off", 32'(valid0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
